// File: rtl/miner_csr_bridge.sv
// Avalon-MM register bridge and job sequencer for the SHA3-256 miner core.
// Latency: writes take effect on the next clk edge; reads return data 1 cycle after avs_read.
// Backpressure: none, the slave accepts every access and always answers with fixed latency 1.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   avs_*                       HPS lightweight Avalon-MM slave (5-bit word address)
//   header/difficulty/
//   start_nonce/control         active job driven to the miner; control[0] is run
//   solution/status/miner_irq   miner results and match/halt indication
//   irq                         host interrupt (irq_pending & irq_enable)
//
// Build option: define MINER_CSR_JOBQ_EN to add a one-deep job queue. A start
// received while RUN is then parked and launched automatically on the next capture.
module miner_csr_bridge #(
  parameter int unsigned STOP_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   avs_address,
  input  logic         avs_write,
  input  logic [31:0]  avs_writedata,
  input  logic         avs_read,
  output logic [31:0]  avs_readdata,
  output logic         avs_readdatavalid,
  output logic [255:0] header,
  output logic [255:0] difficulty,
  output logic [63:0]  start_nonce,
  output logic [18:0]  control,
  input  logic [63:0]  solution,
  input  logic [6:0]   status,
  input  logic         miner_irq,
  output logic         irq
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUIESCE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_FOUND   = 2'd3;

  // Shadow registers written by the host
  logic [255:0] hdr_sh_q, diff_sh_q;
  logic [63:0]  nonce_sh_q;
  logic [18:1]  ctrl_sh_q;
  logic         irq_en_q;

  // Active job and sequencer state
  logic [255:0] hdr_q, hdr_d, diff_q, diff_d;
  logic [63:0]  nonce_q, nonce_d, sol_q, sol_d;
  logic [18:1]  ctrl_q, ctrl_d;
  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  found_q, found_d;
  logic         pend_q, pend_d;
  logic [31:0]  rdata_q, rd_mux;
  logic         rvld_q;
  logic         queued;

  logic wr_cmd, start_cmd, stop_cmd, clr_cmd, start_now;

  assign wr_cmd    = avs_write && (avs_address == 5'd19);
  // A combined start+stop is treated as a plain stop.
  assign stop_cmd  = wr_cmd && avs_writedata[1];
  assign start_cmd = wr_cmd && avs_writedata[0] && !avs_writedata[1];
  assign clr_cmd   = wr_cmd && avs_writedata[2];

`ifdef MINER_CSR_JOBQ_EN
  logic [255:0] qhdr_q, qhdr_d, qdiff_q, qdiff_d;
  logic [63:0]  qnonce_q, qnonce_d;
  logic [18:1]  qctrl_q, qctrl_d;
  logic         queued_q, queued_d;

  assign queued    = queued_q;
  // In RUN a start is parked in the queue instead of restarting the engine.
  assign start_now = start_cmd && (fsm_q != S_RUN);
`else
  assign queued    = 1'b0;
  assign start_now = start_cmd;
`endif

  // Host-side shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_sh_q   <= '0;
      diff_sh_q  <= '0;
      nonce_sh_q <= '0;
      ctrl_sh_q  <= '0;
      irq_en_q   <= 1'b0;
    end else if (avs_write) begin
      case (avs_address[4:3])
        2'b00: hdr_sh_q[{avs_address[2:0], 5'd0} +: 32]  <= avs_writedata;
        2'b01: diff_sh_q[{avs_address[2:0], 5'd0} +: 32] <= avs_writedata;
        2'b10: begin
          case (avs_address[2:0])
            3'd0:    nonce_sh_q[31:0]  <= avs_writedata;
            3'd1:    nonce_sh_q[63:32] <= avs_writedata;
            3'd2:    ctrl_sh_q         <= avs_writedata[18:1];
            3'd7:    irq_en_q          <= avs_writedata[0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Sequencer next state
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    diff_d  = diff_q;
    nonce_d = nonce_q;
    ctrl_d  = ctrl_q;
    sol_d   = sol_q;
    found_d = found_q;
    pend_d  = pend_q && !clr_cmd;
`ifdef MINER_CSR_JOBQ_EN
    qhdr_d   = qhdr_q;
    qdiff_d  = qdiff_q;
    qnonce_d = qnonce_q;
    qctrl_d  = qctrl_q;
    queued_d = queued_q;
`endif
    if (stop_cmd) begin
      fsm_d = S_IDLE;
`ifdef MINER_CSR_JOBQ_EN
      queued_d = 1'b0;
`endif
    end else if (start_now) begin
      hdr_d   = hdr_sh_q;
      diff_d  = diff_sh_q;
      nonce_d = nonce_sh_q;
      ctrl_d  = ctrl_sh_q;
      cnt_d   = 4'(STOP_CYCLES);
      fsm_d   = S_QUIESCE;
`ifdef MINER_CSR_JOBQ_EN
      // The fresh commit supersedes any parked job.
      queued_d = 1'b0;
`endif
    end else begin
      case (fsm_q)
        S_QUIESCE: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) fsm_d = S_RUN;
        end
        S_RUN: begin
          if (miner_irq) begin
            sol_d   = solution;
            found_d = found_q + 32'd1;
            pend_d  = 1'b1;     // capture beats a coincident irq_clear
            fsm_d   = S_FOUND;
`ifdef MINER_CSR_JOBQ_EN
            if (queued_q) begin
              hdr_d    = qhdr_q;
              diff_d   = qdiff_q;
              nonce_d  = qnonce_q;
              ctrl_d   = qctrl_q;
              cnt_d    = 4'(STOP_CYCLES);
              fsm_d    = S_QUIESCE;
              queued_d = 1'b0;
            end
`endif
          end
`ifdef MINER_CSR_JOBQ_EN
          if (start_cmd) begin
            qhdr_d   = hdr_sh_q;
            qdiff_d  = diff_sh_q;
            qnonce_d = nonce_sh_q;
            qctrl_d  = ctrl_sh_q;
            queued_d = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      diff_q  <= '0;
      nonce_q <= '0;
      ctrl_q  <= '0;
      sol_q   <= '0;
      found_q <= '0;
      pend_q  <= 1'b0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      diff_q  <= diff_d;
      nonce_q <= nonce_d;
      ctrl_q  <= ctrl_d;
      sol_q   <= sol_d;
      found_q <= found_d;
      pend_q  <= pend_d;
      rdata_q <= avs_read ? rd_mux : 32'd0;
      rvld_q  <= avs_read;
    end
  end

`ifdef MINER_CSR_JOBQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      qhdr_q   <= '0;
      qdiff_q  <= '0;
      qnonce_q <= '0;
      qctrl_q  <= '0;
      queued_q <= 1'b0;
    end else begin
      qhdr_q   <= qhdr_d;
      qdiff_q  <= qdiff_d;
      qnonce_q <= qnonce_d;
      qctrl_q  <= qctrl_d;
      queued_q <= queued_d;
    end
  end
`endif

  // Read mux sees pre-write state, so a same-cycle write is not reflected.
  always_comb begin
    rd_mux = 32'd0;
    case (avs_address[4:3])
      2'b00: rd_mux = hdr_sh_q[{avs_address[2:0], 5'd0} +: 32];
      2'b01: rd_mux = diff_sh_q[{avs_address[2:0], 5'd0} +: 32];
      2'b10: begin
        case (avs_address[2:0])
          3'd0:    rd_mux = nonce_sh_q[31:0];
          3'd1:    rd_mux = nonce_sh_q[63:32];
          3'd2:    rd_mux = {13'd0, ctrl_sh_q, 1'b0};
          3'd4:    rd_mux = {14'd0, queued, pend_q, fsm_q, 7'd0, status};
          3'd5:    rd_mux = sol_q[31:0];
          3'd6:    rd_mux = sol_q[63:32];
          3'd7:    rd_mux = {31'd0, irq_en_q};
          default: rd_mux = 32'd0;
        endcase
      end
      default: rd_mux = (avs_address == 5'd24) ? found_q : 32'd0;
    endcase
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvld_q;
  assign header            = hdr_q;
  assign difficulty        = diff_q;
  assign start_nonce       = nonce_q;
  // run is high only while the job is executing or frozen on a solution
  assign control           = {ctrl_q, (fsm_q == S_RUN) || (fsm_q == S_FOUND)};
  assign irq               = pend_q && irq_en_q;

endmodule

// File: tb/tb_miner_csr_bridge.sv
// Directed bench for miner_csr_bridge: read responses go through a scoreboard
// queue checked by an independent monitor; job outputs are checked inline.
module tb_miner_csr_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   avs_address = '0;
  logic         avs_write = 1'b0;
  logic [31:0]  avs_writedata = '0;
  logic         avs_read = 1'b0;
  logic [31:0]  avs_readdata;
  logic         avs_readdatavalid;
  logic [255:0] header, difficulty;
  logic [63:0]  start_nonce;
  logic [18:0]  control;
  logic [63:0]  solution = '0;
  logic [6:0]   status = '0;
  logic         miner_irq = 1'b0;
  logic         irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
    int          addr;
  } exp_t;
  exp_t sb[$];

  miner_csr_bridge #(.STOP_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .header(header), .difficulty(difficulty), .start_nonce(start_nonce), .control(control),
    .solution(solution), .status(status), .miner_irq(miner_irq), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every readdatavalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL spurious_rdv: readdata=%08h with no read outstanding", avs_readdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (avs_readdata !== e.dat || cyc != e.cyc) begin
          bad++;
          $display("FAIL rd_addr%0d: got %08h at cycle %0d, expected %08h at cycle %0d",
                   e.addr, avs_readdata, cyc, e.dat, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    avs_read = 1'b1; avs_address = a;
    sb.push_back('{dat: exp, cyc: cyc + 1, addr: int'(a)});
    tick();
    avs_read = 1'b0;
  endtask

  initial begin
    // Reset
    ticks(3);
    chk("rst_header", header, '0);
    chk("rst_control", control, '0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_rdv", avs_readdatavalid, 1'b0);
    chk("rst_rdata", avs_readdata, '0);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) rd(5'(a), 32'd0);

    // Load shadows and start a job
    for (int w = 0; w < 8; w++) wr(5'(w), 32'h1111_1111);
    for (int w = 8; w < 16; w++) wr(5'(w), 32'hFFFF_FFFF);
    wr(5'd16, 32'd5);
    wr(5'd17, 32'd0);
    wr(5'd18, 32'h0003_000C);
    rd(5'd18, 32'h0003_000C);
    rd(5'd3, 32'h1111_1111);
    chk("hdr_before_start", header, '0);
    wr(5'd19, 32'd1);
    chk("hdr_commit", header, {8{32'h1111_1111}});
    chk("diff_commit", difficulty, {256{1'b1}});
    chk("nonce_commit", start_nonce, 64'd5);
    chk("ctrl_commit", control, 19'h3000C);
    for (int i = 0; i < 4; i++) begin
      chk("run_low_quiesce", control[0], 1'b0);
      tick();
    end
    chk("run_high", control[0], 1'b1);
    chk("ctrl_run", control, 19'h3000D);
    status = 7'h55;
    rd(5'd20, 32'h0000_8055);

    // Capture in RUN
    wr(5'd23, 32'd1);
    rd(5'd23, 32'd1);
    chk("irq_before_capture", irq, 1'b0);
    solution = 64'h1234; miner_irq = 1'b1;
    tick();
    miner_irq = 1'b0;
    chk("irq_after_capture", irq, 1'b1);
    chk("run_in_found", control[0], 1'b1);
    rd(5'd21, 32'h0000_1234);
    rd(5'd22, 32'd0);
    rd(5'd24, 32'd1);
    rd(5'd20, 32'h0001_C055);
    wr(5'd19, 32'd4);
    chk("irq_cleared", irq, 1'b0);
    rd(5'd20, 32'h0000_C055);
    // miner_irq outside RUN is ignored
    solution = 64'h9999; miner_irq = 1'b1;
    tick();
    miner_irq = 1'b0;
    rd(5'd24, 32'd1);
    rd(5'd21, 32'h0000_1234);

    // Restart from FOUND, shadow write while running
    wr(5'd19, 32'd1);
    ticks(4);
    chk("run_job2", control[0], 1'b1);
    wr(5'd8, 32'h1234_5678);
    chk("diff_hold_in_run", difficulty, {256{1'b1}});
    rd(5'd8, 32'h1234_5678);

    // Start+stop together: stop wins, active job retained
    wr(5'd19, 32'd3);
    chk("run_after_stop", control[0], 1'b0);
    rd(5'd20, 32'h0000_0055);
    chk("diff_retained", difficulty, {256{1'b1}});
    wr(5'd19, 32'd1);
    chk("diff_recommit", difficulty, {{224{1'b1}}, 32'h1234_5678});

    // irq_clear coincident with capture
    ticks(4);
    solution = 64'h0000_0002_0000_BEEF; miner_irq = 1'b1;
    wr(5'd19, 32'd4);
    miner_irq = 1'b0;
    chk("pend_beats_clear", irq, 1'b1);
    rd(5'd24, 32'd2);
    rd(5'd21, 32'h0000_BEEF);
    rd(5'd22, 32'h0000_0002);

    // Read returns pre-write value on a same-cycle write
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 5'd23; avs_writedata = 32'd0;
    sb.push_back('{dat: 32'd1, cyc: cyc + 1, addr: 23});
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
    rd(5'd23, 32'd0);
    chk("irq_masked", irq, 1'b0);

    // Reset mid-job
    wr(5'd19, 32'd1);
    ticks(4);
    chk("run_before_rst", control[0], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ctrl_after_rst", control, '0);
    chk("hdr_after_rst", header, '0);
    rd(5'd24, 32'd0);
    rd(5'd8, 32'd0);

`ifdef MINER_CSR_JOBQ_EN
    // Job queue: start in RUN parks the job, capture launches it
    wr(5'd16, 32'd5);
    wr(5'd19, 32'd1);
    ticks(4);
    wr(5'd16, 32'd100);
    wr(5'd19, 32'd1);
    chk("q_nonce_hold", start_nonce, 64'd5);
    chk("q_run_hold", control[0], 1'b1);
    rd(5'd20, 32'h0002_8055);
    solution = 64'd7; miner_irq = 1'b1;
    tick();
    miner_irq = 1'b0;
    chk("q_nonce_load", start_nonce, 64'd100);
    for (int i = 0; i < 4; i++) begin
      chk("q_run_low", control[0], 1'b0);
      tick();
    end
    chk("q_run_high", control[0], 1'b1);
    rd(5'd24, 32'd1);
    rd(5'd20, 32'h0001_8055);
`endif

    // Drain outstanding reads within a bounded window
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d reads unanswered, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/miner_csr_bridge.md
# miner_csr_bridge

Host-side register bridge and job sequencer for the SHA3-256 mining engine. Sits between the HPS lightweight Avalon-MM bus and the miner core. It holds header, difficulty, start nonce and control fields in shadow registers and commits them atomically as a job. It sequences the miner's run signal through a quiesce window, captures the solution when the engine raises its IRQ, and presents a maskable interrupt plus a found-counter to software.

## Interface

Parameters:
- STOP_CYCLES, 4: cycles run is held low before a new job starts; legal range 3..15, needed because the miner control path has a 2-flop synchronizer.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- avs_address  in  5  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, valid with avs_readdatavalid.
- avs_readdatavalid  out  1  one-cycle pulse, fixed read latency 1.
- header  out  256  active job header to miner.
- difficulty  out  256  active job target to miner.
- start_nonce  out  64  active job start nonce to miner.
- control  out  19  miner control: [18:11] padf, [10:3] padl, [2] halt, [1] test, [0] run.
- solution  in  64  miner solution.
- status  in  7  miner status.
- miner_irq  in  1  miner match/halt indication.
- irq  out  1  host interrupt = irq_pending & irq_enable.

## Operation

Word address map (word n covers bits 32n+31:32n of multiword fields). All addresses not listed read 0; writes to them are ignored.
- 0-7: header shadow, RW.
- 8-15: difficulty shadow, RW.
- 16-17: start_nonce shadow (lo/hi), RW.
- 18: control shadow, RW; bits [18:1] only; bit0 reads 0.
- 19: command, W only, reads 0. Bit0 = start, bit1 = stop, bit2 = irq_clear.
- 20: status, RO: {14'b0, queued, irq_pending, fsm[1:0], 7'b0, status[6:0]}.
- 21-22: captured solution lo/hi, RO.
- 23: irq_enable, bit0, RW.
- 24: found counter, RO, 32-bit; increments on each capture and wraps at 2^32.

State machine:
- States are IDLE=0, QUIESCE=1, RUN=2, FOUND=3.
- run (control[0]) = 1 only in RUN and FOUND.
- start, from any state: copy all shadows into the active registers, load the quiesce counter with STOP_CYCLES, and go to QUIESCE.
- QUIESCE: decrement the counter; at 0, go to RUN.
- RUN: when miner_irq = 1, latch solution into the captured register, increment the found counter, set irq_pending, and go to FOUND.
- FOUND: keep run = 1 so the miner stays frozen; wait for start or stop.
- stop, from any state: go to IDLE. The active registers are retained.
- Active outputs change only on a start commit. Shadow writes never disturb a running job.

## Timing

- Reset: header, difficulty, start_nonce, control, and all shadows = 0. Captured solution = 0, found counter = 0, irq_enable = 0, irq_pending = 0, queued = 0, fsm = IDLE. irq = 0, avs_readdata = 0, avs_readdatavalid = 0.
- Write takes effect on the next clk edge. A read returns data one cycle after avs_read, reflecting state before any same-cycle write.
- Start in cycle t: active registers update at t+1 and run is low from t+1 through t+STOP_CYCLES. run rises at t+STOP_CYCLES+1.
- miner_irq is ignored outside RUN. Capture occurs at the first clk edge where RUN and miner_irq are both true. irq rises the cycle after capture if enabled.
- Start and stop written together: stop wins.
- irq_clear in the same cycle as a capture: pending stays 1.
- Start while in QUIESCE: re-commit the shadows and reload the counter.
- rst mid-job: immediate return to reset values; run drops the next cycle.

## Configuration

- MINER_CSR_JOBQ_EN defined: adds a one-deep job queue.
  - A start received in RUN copies the shadows into the queue slot, sets queued, and does not disturb the running job.
  - On capture, if queued = 1: load the queue into the active registers, clear queued, and go directly to QUIESCE. irq_pending is still set.
  - A start in any other state behaves as the base design. A start in RUN with queued already 1 overwrites the queue slot.
  - stop clears queued.
- MINER_CSR_JOBQ_EN undefined: start always restarts immediately; queued reads 0 and no queue storage is synthesized.

## Test plan

- Reset, then read all addresses 0-31: every read returns 0 with readdatavalid exactly one cycle after read.
- Write header = 0x11..., difficulty = 0xFF..FF, nonce = 5, control shadow = 0x3000C, then start: outputs update the next cycle. run is low for 4 cycles then high; status read shows fsm = 2.
- In RUN, drive solution = 0x1234, miner_irq = 1, irq_enable = 1: captured solution reads 0x1234, counter = 1, irq = 1, fsm = 3. Then irq_clear: irq = 0.
- Shadow write to the difficulty words while in RUN: the difficulty output is unchanged until the next start.
- Start+stop in one write from RUN: fsm = IDLE and run = 0. irq_clear coincident with miner_irq capture: irq_pending remains 1.
- With MINER_CSR_JOBQ_EN: start a job, write nonce = 100, start again (queued = 1), pulse miner_irq. start_nonce becomes 100, fsm = QUIESCE, run is low for STOP_CYCLES, and counter = 1.
